// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and writeback select encodings for the 5-stage pipeline
package pipe_pkg;
  localparam logic RST_ENABLED = 1'b1;
  localparam logic WRITE_ENABLED = 1'b1;
  localparam logic [2:0] WB_SEL_ALU = 3'd0;
  localparam logic [2:0] WB_SEL_DMEM = 3'd1;
  localparam logic [2:0] WB_SEL_PC4 = 3'd2;
  localparam logic [2:0] WB_SEL_RS = 3'd3;
  localparam logic [2:0] WB_SEL_LB = 3'd4;
  localparam logic [2:0] WB_SEL_LBU = 3'd5;
  localparam logic [2:0] WB_SEL_LH = 3'd6;
  localparam logic [2:0] WB_SEL_LHU = 3'd7;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_load_fmt.sv
// wb_load_fmt: writeback source select with little-endian sub-word load extraction
module wb_load_fmt
  import pipe_pkg::*;
(
  input  logic [31:0] i_alu,
  input  logic [31:0] i_dmem,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_rs_data,
  input  logic [2:0]  i_sel,
  output logic [31:0] o_wdata
);
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_shift = i_dmem >> {i_alu[1:0], 3'b000};
  assign w_byte = w_shift[7:0];
  // alu[0] is not consulted: misaligned halves never reach writeback
  assign w_half = i_alu[1] ? i_dmem[31:16] : i_dmem[15:0];
  always_comb begin
    o_wdata = i_alu;
    case (i_sel)
      WB_SEL_ALU:  o_wdata = i_alu;
      WB_SEL_DMEM: o_wdata = i_dmem;
      WB_SEL_PC4:  o_wdata = i_pc4;
      WB_SEL_RS:   o_wdata = i_rs_data;
      WB_SEL_LB:   o_wdata = {{24{w_byte[7]}}, w_byte};
      WB_SEL_LBU:  o_wdata = {24'd0, w_byte};
      WB_SEL_LH:   o_wdata = {{16{w_half[15]}}, w_half};
      WB_SEL_LHU:  o_wdata = {16'd0, w_half};
      default:     o_wdata = i_alu;
    endcase
  end
endmodule

// File: rtl/pipe_wb_regfile.sv
// pipe_wb_regfile: writeback stage and architectural register file with write-through read ports
module pipe_wb_regfile
  import pipe_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int DATA_W = 32,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_alu_out,
  input  logic [DATA_W-1:0] wb_dmem_out,
  input  logic [DATA_W-1:0] wb_pc4,
  input  logic [DATA_W-1:0] wb_rs_data_out,
  input  logic [AW-1:0]     wb_rf_waddr,
  input  logic              wb_rf_wena,
  input  logic [2:0]        wb_rf_mux_sel,
  input  logic [AW-1:0]     id_rs_addr,
  input  logic [AW-1:0]     id_rt_addr,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic              wb_commit,
  output logic [31:0]       retire_cnt
);
  logic [DATA_W-1:0] r_regs [REG_COUNT];
  logic              r_commit;
  logic [31:0]       r_retire_cnt;
  logic [DATA_W-1:0] w_wdata;
  logic              w_commit;
  wb_load_fmt u_fmt (
    .i_alu(wb_alu_out),
    .i_dmem(wb_dmem_out),
    .i_pc4(wb_pc4),
    .i_rs_data(wb_rs_data_out),
    .i_sel(wb_rf_mux_sel),
    .o_wdata(w_wdata)
  );
  assign w_commit = wb_rf_wena == WRITE_ENABLED && wb_rf_waddr != AW'(REG_ZERO);
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLED) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      r_commit <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      r_commit <= w_commit;
      if (w_commit) begin
        r_regs[wb_rf_waddr] <= w_wdata;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end
  always_comb begin
    id_rs_data = id_rs_addr == AW'(REG_ZERO) ? '0 :
                 (w_commit && wb_rf_waddr == id_rs_addr) ? w_wdata : r_regs[id_rs_addr];
    id_rt_data = id_rt_addr == AW'(REG_ZERO) ? '0 :
                 (w_commit && wb_rf_waddr == id_rt_addr) ? w_wdata : r_regs[id_rt_addr];
  end
  assign wb_rf_wdata = w_wdata;
  assign wb_commit = r_commit;
  assign retire_cnt = r_retire_cnt;
endmodule

// File: tb/tb_pipe_wb_regfile.sv
// tb_pipe_wb_regfile: directed checks of writeback formatting, register file, bypass and counters
module tb_pipe_wb_regfile;
  logic        clk = 0;
  logic        rst;
  logic [31:0] wb_alu_out, wb_dmem_out, wb_pc4, wb_rs_data_out;
  logic [4:0]  wb_rf_waddr, id_rs_addr, id_rt_addr;
  logic        wb_rf_wena;
  logic [2:0]  wb_rf_mux_sel;
  logic [31:0] id_rs_data, id_rt_data, wb_rf_wdata, retire_cnt;
  logic        wb_commit;
  int checks = 0;
  int failures = 0;

  pipe_wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_alu_out(wb_alu_out), .wb_dmem_out(wb_dmem_out), .wb_pc4(wb_pc4),
    .wb_rs_data_out(wb_rs_data_out), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wena(wb_rf_wena),
    .wb_rf_mux_sel(wb_rf_mux_sel), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .wb_rf_wdata(wb_rf_wdata),
    .wb_commit(wb_commit), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  fmt_sel [12];
  logic [31:0] fmt_alu [12];
  logic [31:0] fmt_exp [12];

  initial begin
    fmt_sel = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd4, 3'd5, 3'd4, 3'd7, 3'd1, 3'd2, 3'd3};
    fmt_alu = '{32'h3, 32'h2, 32'h0, 32'h2, 32'h2, 32'h0, 32'h3, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0};
    fmt_exp = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01, 32'h0000_80FF, 32'hFFFF_80FF,
                32'h0000_0001, 32'h0000_0080, 32'h0000_007F, 32'h0000_7F01, 32'h80FF_7F01,
                32'h0000_0444, 32'h0000_0333};
    rst = 1; wb_alu_out = 0; wb_dmem_out = 0; wb_pc4 = 0; wb_rs_data_out = 0;
    wb_rf_waddr = 0; wb_rf_wena = 0; wb_rf_mux_sel = 0; id_rs_addr = 0; id_rt_addr = 0;
    step();
    step();
    chk("rst_commit", {31'd0, wb_commit}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    rst = 0;
    for (int a = 0; a < 32; a++) begin
      id_rs_addr = 5'(a); id_rt_addr = 5'(31 - a);
      #1;
      chk("rst_rs", id_rs_data, 32'd0);
      chk("rst_rt", id_rt_data, 32'd0);
    end
    // ALU write to r8, bypass visible on both ports before the edge
    wb_rf_mux_sel = 3'd0; wb_alu_out = 32'h1234_5678; wb_rf_waddr = 5'd8; wb_rf_wena = 1;
    id_rs_addr = 5'd8; id_rt_addr = 5'd8;
    #1;
    chk("alu_wdata", wb_rf_wdata, 32'h1234_5678);
    chk("byp_rs", id_rs_data, 32'h1234_5678);
    chk("byp_rt", id_rt_data, 32'h1234_5678);
    chk("pre_commit", {31'd0, wb_commit}, 32'd0);
    step();
    wb_rf_wena = 0;
    #1;
    chk("alu_commit", {31'd0, wb_commit}, 32'd1);
    chk("alu_cnt", retire_cnt, 32'd1);
    chk("reg8_rs", id_rs_data, 32'h1234_5678);
    step();
    chk("commit_pulse_end", {31'd0, wb_commit}, 32'd0);
    // format table with writes disabled: only wb_rf_wdata moves
    wb_dmem_out = 32'h80FF_7F01; wb_pc4 = 32'h444; wb_rs_data_out = 32'h333;
    for (int t = 0; t < 12; t++) begin
      wb_rf_mux_sel = fmt_sel[t]; wb_alu_out = fmt_alu[t];
      #1;
      chk($sformatf("fmt%0d", t), wb_rf_wdata, fmt_exp[t]);
      step();
    end
    chk("nowr_cnt", retire_cnt, 32'd1);
    chk("nowr_commit", {31'd0, wb_commit}, 32'd0);
    chk("nowr_reg8", id_rs_data, 32'h1234_5678);
    // LH into r3
    wb_rf_mux_sel = 3'd6; wb_alu_out = 32'h2; wb_rf_waddr = 5'd3; wb_rf_wena = 1;
    id_rt_addr = 5'd3;
    step();
    wb_rf_wena = 0;
    #1;
    chk("lh_reg3", id_rt_data, 32'hFFFF_80FF);
    chk("lh_cnt", retire_cnt, 32'd2);
    chk("lh_reg8", id_rs_data, 32'h1234_5678);
    // write to r0 is dropped
    wb_rf_mux_sel = 3'd2; wb_pc4 = 32'h40; wb_rf_waddr = 5'd0; wb_rf_wena = 1;
    id_rs_addr = 5'd0; id_rt_addr = 5'd0;
    #1;
    chk("r0_wdata", wb_rf_wdata, 32'h40);
    chk("r0_byp_rs", id_rs_data, 32'd0);
    step();
    wb_rf_wena = 0;
    #1;
    chk("r0_commit", {31'd0, wb_commit}, 32'd0);
    chk("r0_cnt", retire_cnt, 32'd2);
    chk("r0_rt", id_rt_data, 32'd0);
    // commit coincident with reset is discarded
    wb_rf_mux_sel = 3'd0; wb_alu_out = 32'h0000_DEAD; wb_rf_waddr = 5'd5; wb_rf_wena = 1; rst = 1;
    step();
    rst = 0; wb_rf_wena = 0; id_rs_addr = 5'd5; id_rt_addr = 5'd8;
    #1;
    chk("rstw_reg5", id_rs_data, 32'd0);
    chk("rstw_reg8", id_rt_data, 32'd0);
    chk("rstw_cnt", retire_cnt, 32'd0);
    chk("rstw_commit", {31'd0, wb_commit}, 32'd0);
    // counter wrap
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    wb_alu_out = 32'h1; wb_rf_waddr = 5'd9; wb_rf_wena = 1;
    step();
    wb_rf_wena = 0;
    id_rs_addr = 5'd9;
    #1;
    chk("wrap_cnt", retire_cnt, 32'd0);
    chk("wrap_commit", {31'd0, wb_commit}, 32'd1);
    chk("wrap_reg9", id_rs_data, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
